timer_datapath: RTL and testbench
=================================

Name: timer_datapath

Overview:
Countdown timer datapath driven by the timer controller FSM. It holds the HH:MM:SS count and applies the controller's clear, run and per-field up/down pulses. It decrements once per second while running and returns the end-of-count indication that moves the controller from Run to End. Its outputs feed the 7-segment/FND display mux and the digit-blink logic.

Parameters:
P_CLK_HZ, 100_000_000, iClk frequency; the prescaler wraps every P_CLK_HZ cycles (1 s). Set to 4 in simulation.
P_HOUR_MAX, 23, highest hour value; the hour field wraps at this value.

Ports:
iClk  in  1  system clock
iRst  in  1  asynchronous, active-high reset
iRun  in  1  level; count down while high (controller Run state)
iClear  in  1  level/pulse; zero all fields and the prescaler
iHour_Up  in  1  one-cycle pulse; hour +1
iHour_Down  in  1  one-cycle pulse; hour -1
iMin_Up  in  1  one-cycle pulse; minute +1
iMin_Down  in  1  one-cycle pulse; minute -1
iSec_Up  in  1  one-cycle pulse; second +1
iSec_Down  in  1  one-cycle pulse; second -1
oHour  out  5  hour, binary 0..P_HOUR_MAX
oMin  out  6  minute, binary 0..59
oSec  out  6  second, binary 0..59
oZero  out  1  level; high when the count is 00:00:00
oEnd  out  1  one-cycle pulse; count expired (drives the controller's iEnd)
oBlink  out  1  half-second blink phase for set-mode digit flashing

Behaviour:
- Reset (async, iRst=1):
  - oHour, oMin, oSec = 0.
  - Prescaler = 0, oEnd = 0, oBlink = 1.
  - oZero = 1, because it is combinational from the fields.
- Prescaler:
  - Counts 0..P_CLK_HZ-1 only while iRun=1.
  - Holds its value while iRun=0, so pause/resume keeps the fractional second.
  - Tick = cycle in which it wraps P_CLK_HZ-1 -> 0.
- Priority per cycle: iClear > run tick > adjust pulses.
- Clear: the cycle after iClear=1, all fields = 0, prescaler = 0, and oEnd is not asserted.
- Run tick with count non-zero: decrement with borrow.
  - sec 0 -> 59 borrows from min; min 0 -> 59 borrows from hour.
  - Otherwise sec-1.
  - Fields update one cycle after the tick cycle (registered).
- Expiry:
  - When a tick decrements the count to 00:00:00, oEnd pulses high for exactly one cycle, coincident with the fields first reading 0.
  - If iRun=1 while the count is already 00:00:00, oEnd pulses on the first such cycle and then stays low until the count becomes non-zero and expires again. This prevents the controller from hanging in Run.
  - Implemented with an armed flag: set whenever the count is non-zero, cleared when oEnd fires.
- Count at 00:00:00 with iRun=1: no further decrement and no wrap to 23:59:59.
- Adjust pulses:
  - Honoured only when iRun=0.
  - Each field wraps independently, with no carry or borrow: sec/min 59 -> 0 and 0 -> 59; hour P_HOUR_MAX -> 0 and 0 -> P_HOUR_MAX.
  - Up and Down for the same field in the same cycle: no change.
  - Different fields in the same cycle: all applied.
- Adjust pulses while iRun=1: ignored (no field change).
- oZero is combinational: (oHour==0 && oMin==0 && oSec==0).

Optional Feature:
- Macro TIMER_BLINK_EN.
- Defined:
  - A separate free-running half-second counter (P_CLK_HZ/2 cycles) toggles oBlink.
  - Any adjust pulse reloads the counter and forces oBlink=1 for a full half period, so the edited digit stays visible while it is being changed.
  - Reset and clear also set oBlink=1.
- Undefined: oBlink is tied to 1 and no blink counter is synthesised.

Test Plan:
- Reset -> oHour/oMin/oSec=0, oZero=1, oEnd=0, oBlink=1; then iRun=1 with P_CLK_HZ=4 -> a single oEnd pulse one cycle later and no decrement.
- From 00:00:00, pulse iSec_Down once, then iMin_Up twice -> 00:02:59; pulse iHour_Down -> 23:02:59 (no borrow into other fields).
- Load 00:01:00, iRun=1, P_CLK_HZ=4 -> 00:00:59 after 4 cycles.
  - 00:00:00 after 60 ticks (240 cycles), with oEnd high exactly one cycle, aligned to the fields reading 0.
- Load 01:00:00, run 1 tick -> 00:59:59; deassert iRun for 10 cycles (count and prescaler hold), reassert -> next tick after the remaining prescaler cycles.
- iRun=1 with iSec_Up pulsed -> no change; iRun=0 with iSec_Up and iSec_Down in the same cycle -> no change; iClear with a simultaneous tick -> 00:00:00 and oEnd=0.
- Assert iRst mid-count at 05:30:10 -> all outputs return to reset values immediately, asynchronously to iClk.

Source files
------------

// File: rtl/timer_datapath_if.sv
// Timer datapath interface: controller pulses/levels in,
// HH:MM:SS count, expiry and blink phase out.
interface timer_datapath_if;
    logic       iRun;
    logic       iClear;
    logic       iHour_Up;
    logic       iHour_Down;
    logic       iMin_Up;
    logic       iMin_Down;
    logic       iSec_Up;
    logic       iSec_Down;
    logic [4:0] oHour;
    logic [5:0] oMin;
    logic [5:0] oSec;
    logic       oZero;
    logic       oEnd;
    logic       oBlink;

    modport master (
        output iRun, iClear,
        output iHour_Up, iHour_Down,
        output iMin_Up, iMin_Down,
        output iSec_Up, iSec_Down,
        input  oHour, oMin, oSec,
        input  oZero, oEnd, oBlink
    );

    modport slave (
        input  iRun, iClear,
        input  iHour_Up, iHour_Down,
        input  iMin_Up, iMin_Down,
        input  iSec_Up, iSec_Down,
        output oHour, oMin, oSec,
        output oZero, oEnd, oBlink
    );
endinterface

// File: rtl/timer_datapath.sv
// Countdown timer datapath: HH:MM:SS count, 1 s prescaler, expiry pulse.
// Optional blink counter for set-mode digit flashing: define TIMER_BLINK_EN.
module timer_datapath #(
    parameter int P_CLK_HZ   = 100_000_000,
    parameter int P_HOUR_MAX = 23
) (
    input  logic iClk,
    input  logic iRst,
    timer_datapath_if.slave bus
);
    localparam int PW = (P_CLK_HZ > 1) ? $clog2(P_CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(P_CLK_HZ - 1);
    localparam logic [4:0] HMAX = 5'(P_HOUR_MAX);
    localparam logic [5:0] MS_MAX = 6'd59;

    logic [PW-1:0] preQ, preD;
    logic [4:0]    hourQ, hourD;
    logic [5:0]    minQ, minD;
    logic [5:0]    secQ, secD;
    logic          armedQ, armedD;
    logic          endQ, endD;

    logic zeroNow;
    logic oneLeft;
    logic tick;
    logic hUp, hDn, mUp, mDn, sUp, sDn;

    assign zeroNow = (hourQ == '0) && (minQ == '0) && (secQ == '0);
    assign oneLeft = (hourQ == '0) && (minQ == '0) && (secQ == 6'd1);
    assign tick    = bus.iRun && (preQ == PRE_LAST);

    // Up and Down on the same field cancel out
    assign hUp = bus.iHour_Up & ~bus.iHour_Down;
    assign hDn = bus.iHour_Down & ~bus.iHour_Up;
    assign mUp = bus.iMin_Up & ~bus.iMin_Down;
    assign mDn = bus.iMin_Down & ~bus.iMin_Up;
    assign sUp = bus.iSec_Up & ~bus.iSec_Down;
    assign sDn = bus.iSec_Down & ~bus.iSec_Up;

    // Prescaler next value: runs only while iRun, holds on pause
    always_comb begin
        preD = preQ;
        if (bus.iClear) begin
            preD = '0;
        end else if (bus.iRun) begin
            preD = tick ? '0 : preQ + 1'b1;
        end
    end

    // Field next values: clear, then run decrement, then adjust
    always_comb begin
        hourD = hourQ;
        minD  = minQ;
        secD  = secQ;
        if (bus.iClear) begin
            hourD = '0;
            minD  = '0;
            secD  = '0;
        end else if (bus.iRun) begin
            if (tick && !zeroNow) begin
                if (secQ != '0) begin
                    secD = secQ - 6'd1;
                end else begin
                    secD = MS_MAX;
                    if (minQ != '0) begin
                        minD = minQ - 6'd1;
                    end else begin
                        minD  = MS_MAX;
                        hourD = hourQ - 5'd1;
                    end
                end
            end
        end else begin
            if (hUp) hourD = (hourQ == HMAX) ? '0 : hourQ + 5'd1;
            if (hDn) hourD = (hourQ == '0) ? HMAX : hourQ - 5'd1;
            if (mUp) minD  = (minQ == MS_MAX) ? '0 : minQ + 6'd1;
            if (mDn) minD  = (minQ == '0) ? MS_MAX : minQ - 6'd1;
            if (sUp) secD  = (secQ == MS_MAX) ? '0 : secQ + 6'd1;
            if (sDn) secD  = (secQ == '0) ? MS_MAX : secQ - 6'd1;
        end
    end

    // Expiry: fire once per arming, either on the last tick or on
    // running into an already-zero count so the controller leaves Run
    always_comb begin
        endD   = 1'b0;
        armedD = armedQ;
        if (!bus.iClear && armedQ && bus.iRun &&
            (zeroNow || (tick && oneLeft))) begin
            endD = 1'b1;
        end
        if (endD) begin
            armedD = 1'b0;
        end else if (!zeroNow) begin
            armedD = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            preQ   <= '0;
            hourQ  <= '0;
            minQ   <= '0;
            secQ   <= '0;
            armedQ <= 1'b1;
            endQ   <= 1'b0;
        end else begin
            preQ   <= preD;
            hourQ  <= hourD;
            minQ   <= minD;
            secQ   <= secD;
            armedQ <= armedD;
            endQ   <= endD;
        end
    end

    assign bus.oHour = hourQ;
    assign bus.oMin  = minQ;
    assign bus.oSec  = secQ;
    assign bus.oZero = zeroNow;
    assign bus.oEnd  = endQ;

`ifdef TIMER_BLINK_EN
    localparam int HALF = (P_CLK_HZ / 2 > 1) ? P_CLK_HZ / 2 : 1;
    localparam int BW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

    logic [BW-1:0] blinkCnt;
    logic          blinkQ;
    logic          adjAny;

    assign adjAny = bus.iHour_Up | bus.iHour_Down |
                    bus.iMin_Up  | bus.iMin_Down  |
                    bus.iSec_Up  | bus.iSec_Down;

    // Half-second blink phase; edits restart it in the visible phase
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            blinkCnt <= '0;
            blinkQ   <= 1'b1;
        end else if (bus.iClear || adjAny) begin
            blinkCnt <= '0;
            blinkQ   <= 1'b1;
        end else if (blinkCnt == HALF_LAST) begin
            blinkCnt <= '0;
            blinkQ   <= ~blinkQ;
        end else begin
            blinkCnt <= blinkCnt + 1'b1;
        end
    end

    assign bus.oBlink = blinkQ;
`else
    assign bus.oBlink = 1'b1;
`endif
endmodule

// File: tb/tb_timer_datapath.sv
// Self-checking bench for timer_datapath with P_CLK_HZ=4.
// Vector table for adjust/clear, directed sequences for run/pause/reset.
module tb_timer_datapath;
    localparam logic [5:0] HU = 6'b100000;
    localparam logic [5:0] HD = 6'b010000;
    localparam logic [5:0] MU = 6'b001000;
    localparam logic [5:0] MD = 6'b000100;
    localparam logic [5:0] SU = 6'b000010;
    localparam logic [5:0] SD = 6'b000001;
    localparam logic [5:0] NA = 6'b000000;

    typedef struct {
        logic       run;
        logic       clr;
        logic [5:0] adj;
        int         h;
        int         m;
        int         s;
        logic       z;
        logic       e;
    } vec_t;

    logic iClk;
    logic iRst;
    int   checks;
    int   errors;
    int   endSeen;
    vec_t vecs[11];

    timer_datapath_if bus();

    timer_datapath #(
        .P_CLK_HZ  (4),
        .P_HOUR_MAX(23)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .bus (bus.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic drive(input logic run, input logic clr,
                         input logic [5:0] adj);
        bus.iRun   = run;
        bus.iClear = clr;
        {bus.iHour_Up, bus.iHour_Down,
         bus.iMin_Up, bus.iMin_Down,
         bus.iSec_Up, bus.iSec_Down} = adj;
    endtask

    task automatic step(input logic run, input logic clr,
                        input logic [5:0] adj);
        drive(run, clr, adj);
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string name, input int h, input int m,
                       input int s, input logic z, input logic e);
        checks++;
        if (int'(bus.oHour) != h || int'(bus.oMin) != m ||
            int'(bus.oSec) != s || bus.oZero !== z || bus.oEnd !== e) begin
            errors++;
            $display("FAIL %s: got %0d:%0d:%0d z=%b e=%b, want %0d:%0d:%0d z=%b e=%b",
                     name, bus.oHour, bus.oMin, bus.oSec, bus.oZero,
                     bus.oEnd, h, m, s, z, e);
        end
    endtask

    task automatic chkBit(input string name, input logic act,
                          input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{1'b0, 1'b0, SD,      0,  0, 59, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, MU,      0,  1, 59, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, MU,      0,  2, 59, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, HD,     23,  2, 59, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, SU|SD,  23,  2, 59, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, SU,     23,  2, 59, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, NA,      0,  0,  0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, HU|MD|SU, 1, 59,  1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, HD|MU|SD, 0,  0,  0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, HD,     23,  0,  0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, HU,      0,  0,  0, 1'b1, 1'b0};

        iRst = 1'b1;
        drive(1'b0, 1'b0, NA);
        repeat (2) @(posedge iClk);
        #1;
        chk("reset", 0, 0, 0, 1'b1, 1'b0);
        chkBit("reset_blink", bus.oBlink, 1'b1);
        iRst = 1'b0;

        step(1'b1, 1'b0, NA);
        chk("zero_run_end", 0, 0, 0, 1'b1, 1'b1);
        step(1'b1, 1'b0, NA);
        chk("zero_run_once", 0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b1, NA);
        chk("clear0", 0, 0, 0, 1'b1, 1'b0);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].run, vecs[i].clr, vecs[i].adj);
            chk($sformatf("vec%0d", i), vecs[i].h, vecs[i].m,
                vecs[i].s, vecs[i].z, vecs[i].e);
        end

        step(1'b0, 1'b1, NA);
        step(1'b0, 1'b0, MU);
        chk("load_1min", 0, 1, 0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, NA);
        chk("pre_first_tick", 0, 1, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, NA);
        chk("first_tick", 0, 0, 59, 1'b0, 1'b0);
        endSeen = 0;
        for (int i = 1; i <= 59; i++) begin
            for (int k = 0; k < 3; k++) begin
                step(1'b1, 1'b0, NA);
                if (bus.oEnd) endSeen++;
            end
            step(1'b1, 1'b0, NA);
            chk($sformatf("tick%0d", i), 0, 0, 59 - i,
                (i == 59), (i == 59));
        end
        checks++;
        if (endSeen != 0) begin
            errors++;
            $display("FAIL end_between_ticks: got %0d pulses, want 0",
                     endSeen);
        end
        step(1'b1, 1'b0, NA);
        chk("end_single", 0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 1'b0, NA);
        chk("no_wrap", 0, 0, 0, 1'b1, 1'b0);

        step(1'b0, 1'b1, NA);
        step(1'b0, 1'b0, HU);
        chk("load_1h", 1, 0, 0, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, NA);
        chk("borrow_hour", 0, 59, 59, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, NA);
        repeat (10) step(1'b0, 1'b0, NA);
        chk("pause_hold", 0, 59, 59, 1'b0, 1'b0);
        step(1'b1, 1'b0, NA);
        chk("resume_wait", 0, 59, 59, 1'b0, 1'b0);
        step(1'b1, 1'b0, NA);
        chk("resume_tick", 0, 59, 58, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, NA);
        chk("pre_clear_tick", 0, 59, 58, 1'b0, 1'b0);
        step(1'b1, 1'b1, NA);
        chk("clear_over_tick", 0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, NA);
        chk("after_clear", 0, 0, 0, 1'b1, 1'b0);

        repeat (5) step(1'b0, 1'b0, HU);
        repeat (30) step(1'b0, 1'b0, MD);
        repeat (10) step(1'b0, 1'b0, SU);
        chk("load_053010", 5, 30, 10, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, NA);
        chk("mid_count", 5, 30, 10, 1'b0, 1'b0);
        #2;
        iRst = 1'b1;
        #1;
        chk("async_reset", 0, 0, 0, 1'b1, 1'b0);
        chkBit("async_reset_blink", bus.oBlink, 1'b1);
        drive(1'b0, 1'b0, NA);
        @(posedge iClk);
        #1;
        iRst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
